// File: rtl/hd44780_monitor.sv
// rtl/hd44780_monitor.sv - passive HD44780 8-bit bus decoder with DDRAM mirror
// Samples RS/E/D, decodes writes on E falling edges, mirrors the 80-byte DDRAM.
module hd44780_monitor #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CLEAR_FILL  = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_e,
    input  logic [7:0] lcd_d,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] ac,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       err,
    output logic       update
);
    localparam int NCELLS = 80;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    // Two visible DDRAM lines (0x00-0x27, 0x40-0x67) packed into 0..79.
    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endfunction

    function automatic logic [6:0] lin(input logic [6:0] a);
        return a[6] ? a - 7'd24 : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc)
            return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else
            return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    endfunction

    // Each stage holds {E, RS, D[7:0]}; the history stage keeps the values seen while E was high.
    logic [9:0] sync_q [SYNC_STAGES];
    logic [9:0] hist_q;
    logic       fall;
    logic [7:0] d_h;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= {lcd_e, lcd_rs, lcd_d};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = hist_q[9] & ~sync_q[SYNC_STAGES-1][9];
    assign d_h  = hist_q[7:0];

    state_t     state_q;
    logic [6:0] fill_q;
    logic [6:0] ac_q;
    logic       id_q;
    logic       ddram_q;
    logic       disp_q, cur_q, blink_q, err_q, upd_q;
    logic [7:0] rd_q;
    logic [7:0] mem [NCELLS];

    logic       wr_en;
    logic [6:0] wr_idx;
    logic [7:0] wr_val;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = fill_q;
        wr_val = CLEAR_FILL;
        if (!reset) begin
            if (state_q == S_FILL) begin
                wr_en = 1'b1;
            end else if (fall && hist_q[8] && ddram_q) begin
                wr_en  = 1'b1;
                wr_idx = lin(ac_q);
                wr_val = d_h;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            fill_q  <= '0;
            ac_q    <= '0;
            id_q    <= 1'b1;
            ddram_q <= 1'b1;
            disp_q  <= 1'b0;
            cur_q   <= 1'b0;
            blink_q <= 1'b0;
            err_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    if (fall) err_q <= 1'b1;
                    fill_q <= fill_q + 7'd1;
                    if (fill_q == 7'(NCELLS - 1)) begin
                        state_q <= S_IDLE;
                        upd_q   <= 1'b1;
                    end
                end
                default: begin
                    if (fall && hist_q[8]) begin
                        if (ddram_q) begin
                            ac_q  <= ac_step(ac_q, id_q);
                            upd_q <= 1'b1;
                        end
                    end else if (fall) begin
                        casez (d_h)
                            8'b1???????: begin
                                ddram_q <= 1'b1;
                                if (addr_valid(d_h[6:0])) begin
                                    ac_q  <= d_h[6:0];
                                    upd_q <= 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            8'b01??????: ddram_q <= 1'b0;
                            8'b001?????: if (!d_h[4]) err_q <= 1'b1;
                            8'b0001????: begin
                                if (!d_h[3]) begin
                                    ac_q  <= ac_step(ac_q, d_h[2]);
                                    upd_q <= 1'b1;
                                end
                            end
                            8'b00001???: begin
                                disp_q  <= d_h[2];
                                cur_q   <= d_h[1];
                                blink_q <= d_h[0];
                            end
                            8'b000001??: id_q <= d_h[1];
                            8'b0000001?: begin
                                ac_q  <= '0;
                                upd_q <= 1'b1;
                            end
                            8'b00000001: begin
                                ac_q    <= '0;
                                id_q    <= 1'b1;
                                fill_q  <= '0;
                                state_q <= S_FILL;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rd_q <= '0;
        else       rd_q <= addr_valid(rd_addr) ? mem[lin(rd_addr)] : 8'h00;
    end

    assign rd_data    = rd_q;
    assign ac         = ac_q;
    assign display_on = disp_q;
    assign cursor_on  = cur_q;
    assign blink_on   = blink_q;
    assign busy       = (state_q == S_FILL);
    assign err        = err_q;
    assign update     = upd_q;
endmodule

// File: tb/tb_hd44780_monitor.sv
// tb/tb_hd44780_monitor.sv - scoreboard bench for hd44780_monitor
// Reference model of the LCD state; update pulses are checked against a queue of expected ac.
module tb_hd44780_monitor;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcd_rs = 1'b0, lcd_e = 1'b0;
    logic [7:0] lcd_d = 8'h00;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_data;
    logic [6:0] ac;
    logic       display_on, cursor_on, blink_on, busy, err, update;

    hd44780_monitor #(.SYNC_STAGES(2), .CLEAR_FILL(8'h20)) dut (
        .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_d(lcd_d),
        .rd_addr(rd_addr), .rd_data(rd_data), .ac(ac), .display_on(display_on),
        .cursor_on(cursor_on), .blink_on(blink_on), .busy(busy), .err(err), .update(update)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [7:0] m_mem [128];
    int         m_ac;
    bit         m_id, m_ddram, m_disp, m_cur, m_blink, m_err, m_busy;
    int         sb[$];

    function automatic bit m_valid(input int a);
        return (a >= 0 && a <= 'h27) || (a >= 'h40 && a <= 'h67);
    endfunction

    // Visible cells form a ring of 80 positions: 0x00..0x27 then 0x40..0x67.
    function automatic int m_step(input int a, input bit inc);
        int pos;
        pos = (a < 'h40) ? a : a - 'h40 + 40;
        pos = inc ? (pos + 1) % 80 : (pos + 79) % 80;
        return (pos < 40) ? pos : pos - 40 + 'h40;
    endfunction

    function automatic void m_fill();
        for (int a = 0; a < 128; a++) m_mem[a] = m_valid(a) ? 8'h20 : 8'h00;
    endfunction

    function automatic void m_reset();
        m_fill();
        m_ac = 0; m_id = 1; m_ddram = 1;
        m_disp = 0; m_cur = 0; m_blink = 0; m_err = 0; m_busy = 1;
        sb.delete();
        sb.push_back(0);
    endfunction

    function automatic void m_xfer(input bit rs, input logic [7:0] d);
        if (m_busy) begin
            m_err = 1;
        end else if (rs) begin
            if (m_ddram) begin
                m_mem[m_ac] = d;
                m_ac = m_step(m_ac, m_id);
                sb.push_back(m_ac);
            end
        end else if (d >= 8'h80) begin
            m_ddram = 1;
            if (m_valid(int'(d) - 'h80)) begin
                m_ac = int'(d) - 'h80;
                sb.push_back(m_ac);
            end else begin
                m_err = 1;
            end
        end else if (d >= 8'h40) begin
            m_ddram = 0;
        end else if (d >= 8'h20) begin
            if (d[4] == 1'b0) m_err = 1;
        end else if (d >= 8'h10) begin
            if (d[3] == 1'b0) begin
                m_ac = m_step(m_ac, d[2]);
                sb.push_back(m_ac);
            end
        end else if (d >= 8'h08) begin
            m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
        end else if (d >= 8'h04) begin
            m_id = d[1];
        end else if (d >= 8'h02) begin
            m_ac = 0;
            sb.push_back(0);
        end else if (d == 8'h01) begin
            m_fill();
            m_ac = 0; m_id = 1; m_busy = 1;
            sb.push_back(0);
        end else begin
            m_err = 1;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every update pulse must match the next expected ac in the queue.
    always @(negedge clk) begin
        if (!reset && update) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL update_unexpected: got pulse with ac=0x%0h, expected no pulse", ac);
            end else begin
                int e;
                e = sb.pop_front();
                if (int'(ac) != e) begin
                    n_err++;
                    $display("FAIL update_ac: got 0x%0h, expected 0x%0h", ac, e);
                end
            end
        end
    end

    task automatic lcd_write(input bit rs, input logic [7:0] d);
        @(posedge clk); #1; lcd_rs = rs; lcd_d = d;
        @(posedge clk); #1; lcd_e = 1'b1;
        repeat (2) @(posedge clk);
        #1; lcd_e = 1'b0;
        m_xfer(rs, d);
        repeat (6) @(posedge clk);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1; reset = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_d = 8'h00;
        repeat (3) @(posedge clk);
        #1; m_reset(); reset = 1'b0;
    endtask

    task automatic count_busy();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 80);
        m_busy = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (busy) chk("busy_timeout", 1, 0);
        m_busy = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic rd_chk(input logic [6:0] a);
        @(posedge clk); #1; rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("cell_%02h", a), int'(rd_data), int'(m_mem[a]));
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_ac"}, int'(ac), m_ac);
        chk({tag, "_disp"}, int'(display_on), int'(m_disp));
        chk({tag, "_cur"}, int'(cursor_on), int'(m_cur));
        chk({tag, "_blink"}, int'(blink_on), int'(m_blink));
        chk({tag, "_err"}, int'(err), int'(m_err));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and power-up fill
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_update", int'(update), 0);
        reset_pulse();
        count_busy();
        check_state("reset");
        rd_chk(7'h00); rd_chk(7'h27); rd_chk(7'h40); rd_chk(7'h67);

        // Sequential writes
        lcd_write(0, 8'h80); lcd_write(1, 8'h48); lcd_write(1, 8'h69);
        check_state("hi");
        rd_chk(7'h00); rd_chk(7'h01);

        // Line-1 end wraps to line-2 start
        lcd_write(0, 8'hA7); lcd_write(1, 8'h41); lcd_write(1, 8'h42);
        check_state("wrap_inc");
        rd_chk(7'h27); rd_chk(7'h40);

        // Decrement wraps
        lcd_write(0, 8'h04); lcd_write(0, 8'hC0); lcd_write(1, 8'h5A);
        check_state("wrap_dec1");
        lcd_write(0, 8'h80); lcd_write(1, 8'h31);
        check_state("wrap_dec2");
        rd_chk(7'h40); rd_chk(7'h00);

        // Invalid DDRAM address, then CGRAM data is discarded
        lcd_write(0, 8'h85); lcd_write(0, 8'hA8);
        check_state("bad_addr");
        lcd_write(0, 8'h40); lcd_write(1, 8'h55);
        check_state("cgram");
        rd_chk(7'h05); rd_chk(7'h00);

        // Reset mid-fill restarts the fill
        reset_pulse();
        repeat (30) @(posedge clk);
        reset_pulse();
        count_busy();
        check_state("rst_mid");

        // Display control, then clear with a write dropped during fill
        lcd_write(0, 8'h0E);
        check_state("dispctl");
        lcd_write(0, 8'h80); lcd_write(1, 8'h77);
        lcd_write(0, 8'h01); lcd_write(1, 8'h33);
        wait_idle();
        check_state("clear");
        rd_chk(7'h00); rd_chk(7'h27); rd_chk(7'h40); rd_chk(7'h67);

        // Randomized transfers
        for (int i = 0; i < 200; i++) begin
            bit         rs;
            logic [7:0] d;
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (i % 50 == 49) begin
                rs = 0; d = 8'h01;
            end else if (!rs && $urandom_range(0, 2) == 0) begin
                d = 8'h80 | 8'($urandom_range(0, 127));
            end
            lcd_write(rs, d);
            if (!rs && d == 8'h01) begin
                if ($urandom_range(0, 1) == 1) lcd_write(1, 8'($urandom));
                wait_idle();
            end
            check_state($sformatf("rnd%0d", i));
        end

        repeat (10) @(posedge clk);
        chk("sb_drain", sb.size(), 0);
        for (int a = 0; a < 128; a++) begin
            if (m_valid(a) || a == 'h28 || a == 'h3F || a == 'h68 || a == 'h7F)
                rd_chk(7'(a));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hd44780_monitor.md
Name: hd44780_monitor

Overview:
- Responder-side model of the character LCD bus: passively samples LCD_RS/LCD_E/LCD_D as driven by the LCD write driver, and decodes HD44780 8-bit-mode instructions and data writes.
- Maintains a DDRAM mirror (80 bytes) plus display-control state, so that LCD contents can be read back over JTAG and shown by the desktop simulator.
- Sits in the board top beside the LCD driver and taps the same GPIO_1 nets. It never drives the bus.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on LCD_RS/LCD_E/LCD_D (minimum 2)
- CLEAR_FILL, 8'h20, byte written to every DDRAM cell on clear and on reset

Ports:
- clk  input  1  system clock (FPGA_CLK1_50 domain)
- reset  input  1  synchronous, active-high reset
- lcd_rs  input  1  register select (0 = instruction, 1 = data)
- lcd_e  input  1  enable strobe; transfer takes effect on its falling edge
- lcd_d  input  8  data bus
- rd_addr  input  7  DDRAM address to read (0x00-0x27, 0x40-0x67)
- rd_data  output  8  DDRAM byte at rd_addr, 1-cycle latency
- ac  output  7  current address counter
- display_on, cursor_on, blink_on  output  1 each  display-control bits
- busy  output  1  high while clear-fill is in progress
- err  output  1  sticky: dropped or unsupported transfer since reset
- update  output  1  1-cycle pulse on every DDRAM cell change or ac change

Behaviour:
- Sampling
  - lcd_rs, lcd_d and lcd_e pass through SYNC_STAGES flops, plus one extra history stage.
  - A falling edge is history E=1 and current E=0.
  - The transfer uses the RS/D values held in the history stage, i.e. the values present while E was high.
  - The decoded effect (cell write, ac update, flags) is visible the cycle after edge detection.
- Decode of RS=0: the highest set bit of D selects the instruction.
  - 0x01 Clear: enter FILL state; ac=0; I/D=1.
  - 0x02/0x03 Home: ac=0.
  - 0x04-0x07 Entry mode: store I/D=D[1]. S=D[0] is stored with no effect.
  - 0x08-0x0F Display control: display_on=D[2], cursor_on=D[1], blink_on=D[0].
  - 0x10-0x1F Shift: if S/C=0, move ac by one (R/L=D[2]: 1 = increment) with the wrap rules below. If S/C=1, ignore.
  - 0x20-0x3F Function set: if DL=D[4]=0, set err. Otherwise no effect.
  - 0x40-0x7F Set CGRAM address: mode=CGRAM.
  - 0x80-0xFF Set DDRAM address: mode=DDRAM and ac=D[6:0] if valid. If invalid (0x28-0x3F, 0x68-0x7F), ac is unchanged and err is set.
- Data write (RS=1)
  - In DDRAM mode: cell[ac]=D, then ac steps per I/D.
  - In CGRAM mode: discarded, no err.
- ac wrap rules
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
- FSM states: IDLE, FILL.
  - FILL writes CLEAR_FILL to one cell per cycle over 80 cells (0x00-0x27, then 0x40-0x67), then returns to IDLE.
  - busy=1 exactly in FILL, for 80 cycles.
  - Any E falling edge during FILL is dropped and sets err. The fill is not restarted.
- Reset values
  - ac=0, I/D=1, mode=DDRAM, display_on=0, cursor_on=0, blink_on=0, err=0, update=0, rd_data=0.
  - Synchronizer and history flops reset to 0, so no false edge occurs after reset.
  - FSM enters FILL on the first cycle after reset deasserts, so busy=1 for 80 cycles.
  - Reset asserted mid-FILL restarts the fill from cell 0.
- Read port
  - rd_data=cell[rd_addr] registered, 1-cycle latency.
  - Invalid rd_addr returns 0x00.
  - Read-during-write returns the old value.
- update pulses once per data write, clear completion, home, shift and set-DDRAM-address. It does not pulse for ignored transfers.

Test Plan:
- Reset, then wait 81 cycles: busy high for 80 cycles then low; rd_addr 0x00, 0x27, 0x40, 0x67 each read 0x20; ac=0.
- Instr 0x80, then data 'H' (0x48) and 'i' (0x69): cell 0x00=0x48, cell 0x01=0x69, ac=0x02, two update pulses.
- Instr 0xA7, data 0x41, data 0x42: cell 0x27=0x41, cell 0x40=0x42, ac=0x41.
- Instr 0x04 (decrement), instr 0xC0, data 0x5A: cell 0x40=0x5A, ac=0x27. Then instr 0x80 and data 0x31: cell 0x00=0x31, ac=0x67.
- Instr 0x0E: display_on=1, cursor_on=1, blink_on=0. Then instr 0x01 immediately followed by data 0x33 during busy: the data is dropped, err=1, and after 80 cycles all cells read 0x20 with ac=0.
- Instr 0xA8 (invalid) with ac=0x05: ac stays 0x05, err=1. Instr 0x40 then data 0x55: DDRAM unchanged, no update pulse.
